// File: rtl/fetch_unit_if.sv
// Fetch-stage port bundle: instruction-memory request/response, execute redirect and decode output.
interface fetch_unit_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  imem_req_valid;
    logic                  imem_req_ready;
    logic [DATA_WIDTH-1:0] imem_req_addr;
    logic                  imem_rsp_valid;
    logic [31:0]           imem_rsp_data;
    logic                  redirect_valid;
    logic [DATA_WIDTH-1:0] redirect_pc;
    logic                  inst_valid;
    logic                  inst_ready;
    logic [31:0]           inst;
    logic [DATA_WIDTH-1:0] inst_pc;

    modport master (
        output imem_req_valid, imem_req_addr,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
        input  redirect_valid, redirect_pc,
        output inst_valid, inst, inst_pc,
        input  inst_ready
    );

    modport slave (
        input  imem_req_valid, imem_req_addr,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data,
        output redirect_valid, redirect_pc,
        input  inst_valid, inst, inst_pc,
        output inst_ready
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch: PC, credit-limited imem requests, in-order response queue; FETCH_BYPASS_EN adds a response-to-decode bypass.
// Latency: response to inst_valid is 1 cycle (0 with FETCH_BYPASS_EN when the queue is empty).
// Backpressure: requests stop once queued + in-flight reach FIFO_DEPTH; responses are never stalled.
module fetch_unit #(
    parameter int                    DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] RESET_PC   = '0,
    parameter int                    FIFO_DEPTH = 2
) (
    input logic          clk,
    input logic          rst,
    fetch_unit_if.master bus
);
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = PW + 1;
    localparam logic [DATA_WIDTH-1:0] ALIGN_MASK = ~DATA_WIDTH'(3);

    typedef logic [PW-1:0] ptr_t;
    typedef logic [CW-1:0] cnt_t;

    logic [DATA_WIDTH-1:0] pc;
    cnt_t                  inflight, drop_cnt, q_cnt, inflight_next;
    ptr_t                  af_wr, af_rd, q_wr, q_rd;
    logic [DATA_WIDTH-1:0] af_mem [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] q_pc   [FIFO_DEPTH];
    logic [31:0]           q_inst [FIFO_DEPTH];

    logic                  q_empty, dropping, rsp_fire, byp, out_vld;
    logic                  q_pop, q_push, credit, req_vld, req_fire;
    logic [CW:0]           occupancy;
    logic [DATA_WIDTH-1:0] rsp_pc, out_pc;
    logic [31:0]           out_inst;

    always_comb begin
        q_empty  = (q_cnt == '0);
        dropping = (drop_cnt != '0);
        // A response with nothing tracked belongs to a pre-reset request and is ignored.
        rsp_fire = bus.imem_rsp_valid && (inflight != '0) && !rst;
        rsp_pc   = af_mem[af_rd];
`ifdef FETCH_BYPASS_EN
        byp = q_empty && !dropping && !bus.redirect_valid && rsp_fire;
`else
        byp = 1'b0;
`endif
        out_vld  = !rst && (!q_empty || byp);
        out_inst = '0;
        out_pc   = '0;
        if (!rst && !q_empty) begin
            out_inst = q_inst[q_rd];
            out_pc   = q_pc[q_rd];
        end else if (byp) begin
            out_inst = bus.imem_rsp_data;
            out_pc   = rsp_pc;
        end
        q_pop  = out_vld && bus.inst_ready && !q_empty;
        q_push = rsp_fire && !dropping && !bus.redirect_valid && !(byp && bus.inst_ready);

        // A same-cycle pop frees a slot early so single-cycle memory sustains one fetch per cycle.
        occupancy = {1'b0, inflight} + {1'b0, q_cnt} - {{CW{1'b0}}, q_pop};
        credit    = occupancy < (CW+1)'(FIFO_DEPTH);
        req_vld   = credit && !rst;
        req_fire  = req_vld && bus.imem_req_ready;
        inflight_next = inflight + cnt_t'(req_fire) - cnt_t'(rsp_fire);

        bus.imem_req_valid = req_vld;
        bus.imem_req_addr  = pc;
        bus.inst_valid     = out_vld;
        bus.inst           = out_inst;
        bus.inst_pc        = out_pc;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc       <= RESET_PC & ALIGN_MASK;
            inflight <= '0;
            drop_cnt <= '0;
            af_wr    <= '0;
            af_rd    <= '0;
            q_wr     <= '0;
            q_rd     <= '0;
            q_cnt    <= '0;
        end else begin
            inflight <= inflight_next;
            if (req_fire) af_wr <= af_wr + ptr_t'(1);
            // The address FIFO survives a redirect so stale responses still retire their entry.
            if (rsp_fire) af_rd <= af_rd + ptr_t'(1);
            if (bus.redirect_valid) begin
                pc       <= bus.redirect_pc & ALIGN_MASK;
                drop_cnt <= inflight_next;
                q_wr     <= '0;
                q_rd     <= '0;
                q_cnt    <= '0;
            end else begin
                if (req_fire) pc <= pc + DATA_WIDTH'(4);
                if (rsp_fire && dropping) drop_cnt <= drop_cnt - cnt_t'(1);
                if (q_push) q_wr <= q_wr + ptr_t'(1);
                if (q_pop)  q_rd <= q_rd + ptr_t'(1);
                q_cnt <= q_cnt + cnt_t'(q_push) - cnt_t'(q_pop);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (req_fire) af_mem[af_wr] <= pc;
        if (q_push) begin
            q_pc[q_wr]   <= rsp_pc;
            q_inst[q_wr] <= bus.imem_rsp_data;
        end
    end
endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: reset, throughput, back-pressure, redirect drop, simultaneous events, PC wrap, bypass timing.
module tb_fetch_unit;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

`ifdef FETCH_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    fetch_unit_if #(.DATA_WIDTH(32)) bus0 ();
    fetch_unit_if #(.DATA_WIDTH(32)) bus1 ();

    fetch_unit #(.DATA_WIDTH(32), .RESET_PC(32'h0000_0100), .FIFO_DEPTH(2)) dut (
        .clk(clk), .rst(rst), .bus(bus0)
    );
    fetch_unit #(.DATA_WIDTH(32), .RESET_PC(32'hFFFF_FFFC), .FIFO_DEPTH(2)) dut_wrap (
        .clk(clk), .rst(rst), .bus(bus1)
    );

    typedef struct {
        logic [31:0] addr;
        int          due;
    } mreq_t;

    mreq_t       mq[$];
    logic [31:0] got_pc[$];
    logic [31:0] got_inst[$];
    int          cyc, lat, n_req, n_checks, n_fail;

    function automatic logic [31:0] mdata(input logic [31:0] a);
        return a ^ 32'hC0DE_0013;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic chk_b(input string tag, input logic got, input logic exp);
        n_checks++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, got, exp);
        end
    endtask

    // Record this cycle's handshakes, advance one clock, then drive the memory response for the new cycle.
    task automatic step();
        if (bus0.imem_req_valid === 1'b1 && bus0.imem_req_ready) begin
            mq.push_back('{bus0.imem_req_addr, cyc + lat});
            n_req++;
        end
        if (bus0.imem_rsp_valid && mq.size() > 0) mq.delete(0);
        if (bus0.inst_valid === 1'b1 && bus0.inst_ready) begin
            got_pc.push_back(bus0.inst_pc);
            got_inst.push_back(bus0.inst);
        end
        @(posedge clk);
        #1;
        cyc++;
        if (mq.size() > 0 && mq[0].due <= cyc) begin
            bus0.imem_rsp_valid = 1'b1;
            bus0.imem_rsp_data  = mdata(mq[0].addr);
        end else begin
            bus0.imem_rsp_valid = 1'b0;
            bus0.imem_rsp_data  = '0;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus0.imem_req_ready = 1'b0;
        bus0.inst_ready     = 1'b0;
        bus0.redirect_valid = 1'b0;
        #1;
        chk_b("rst_req_vld", bus0.imem_req_valid, 1'b0);
        chk_b("rst_inst_vld", bus0.inst_valid, 1'b0);
        chk("rst_inst", bus0.inst, 32'h0);
        chk("rst_inst_pc", bus0.inst_pc, 32'h0);
        step();
        mq.delete();
        bus0.imem_rsp_valid = 1'b0;
        bus0.imem_rsp_data  = '0;
        rst = 1'b0;
        got_pc.delete();
        got_inst.delete();
        n_req = 0;
        #1;
        chk_b("post_rst_req_vld", bus0.imem_req_valid, 1'b1);
        chk("post_rst_addr", bus0.imem_req_addr, 32'h0000_0100);
        chk_b("post_rst_inst_vld", bus0.inst_valid, 1'b0);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        cyc      = 0;
        lat      = 1;
        n_req    = 0;
        rst      = 1'b1;
        bus0.imem_req_ready = 1'b0;
        bus0.imem_rsp_valid = 1'b0;
        bus0.imem_rsp_data  = '0;
        bus0.redirect_valid = 1'b0;
        bus0.redirect_pc    = '0;
        bus0.inst_ready     = 1'b0;
        bus1.imem_req_ready = 1'b1;
        bus1.imem_rsp_valid = 1'b0;
        bus1.imem_rsp_data  = '0;
        bus1.redirect_valid = 1'b0;
        bus1.redirect_pc    = '0;
        bus1.inst_ready     = 1'b0;
        step();
        do_reset();

        // Reset fetch: consecutive requests, in-order delivery; wrap instance alongside.
        bus0.imem_req_ready = 1'b1;
        bus0.inst_ready     = 1'b1;
        lat = 1;
        #1;
        chk_b("c0_req_vld", bus0.imem_req_valid, 1'b1);
        chk("c0_addr", bus0.imem_req_addr, 32'h0000_0100);
        chk("wrap_addr0", bus1.imem_req_addr, 32'hFFFF_FFFC);
        step();
        #1;
        chk_b("c1_req_vld", bus0.imem_req_valid, 1'b1);
        chk("c1_addr", bus0.imem_req_addr, 32'h0000_0104);
        chk_b("wrap_vld1", bus1.imem_req_valid, 1'b1);
        chk("wrap_addr1", bus1.imem_req_addr, 32'h0000_0000);
        chk_b("wrap_inst_vld", bus1.inst_valid, 1'b0);
        step();
        #1;
        chk_b("c2_req_vld", bus0.imem_req_valid, 1'b1);
        chk("c2_addr", bus0.imem_req_addr, 32'h0000_0108);
        step();
        step();
        step();
        for (int i = 0; i < 3; i++)
            chk("fetch_seq_pc", (got_pc.size() > i) ? got_pc[i] : 32'hDEAD_BEEF, 32'h0000_0100 + 32'(4 * i));
        chk("fetch_seq_inst", (got_inst.size() > 1) ? got_inst[1] : 32'hDEAD_BEEF, mdata(32'h0000_0104));

        // Response-to-output latency on an empty queue.
        do_reset();
        bus0.imem_req_ready = 1'b1;
        bus0.inst_ready     = 1'b1;
        #1;
        step();
        #1;
        chk_b("byp_rsp_cycle_vld", bus0.inst_valid, BYP);
        step();
        #1;
        chk_b("byp_next_vld", bus0.inst_valid, 1'b1);
        chk("byp_next_pc", bus0.inst_pc, BYP ? 32'h0000_0104 : 32'h0000_0100);

        // Back-pressure: decode stalled for 10 cycles, then released.
        do_reset();
        bus0.imem_req_ready = 1'b1;
        bus0.inst_ready     = 1'b0;
        lat = 1;
        #1;
        repeat (10) step();
        #1;
        chk("bp_req_count", 32'(n_req), 32'd2);
        chk_b("bp_req_vld", bus0.imem_req_valid, 1'b0);
        chk_b("bp_inst_vld", bus0.inst_valid, 1'b1);
        chk("bp_inst_pc", bus0.inst_pc, 32'h0000_0100);
        bus0.inst_ready = 1'b1;
        #1;
        repeat (5) step();
        chk("bp_deliv_count", 32'(got_pc.size()), 32'd5);
        for (int i = 0; i < 5; i++)
            chk("bp_deliv_pc", (got_pc.size() > i) ? got_pc[i] : 32'hDEAD_BEEF, 32'h0000_0100 + 32'(4 * i));
        chk("bp_deliv_inst", (got_inst.size() > 4) ? got_inst[4] : 32'hDEAD_BEEF, mdata(32'h0000_0110));

        // Redirect with two stale responses outstanding, 3-cycle memory.
        do_reset();
        bus0.imem_req_ready = 1'b1;
        bus0.inst_ready     = 1'b1;
        lat = 3;
        #1;
        step();
        step();
        bus0.redirect_valid = 1'b1;
        bus0.redirect_pc    = 32'h0000_2003;
        #1;
        chk_b("rd_full_req_vld", bus0.imem_req_valid, 1'b0);
        step();
        bus0.redirect_valid = 1'b0;
        #1;
        chk_b("rd_n1_inst_vld", bus0.inst_valid, 1'b0);
        chk_b("rd_n1_req_vld", bus0.imem_req_valid, 1'b0);
        chk("rd_n1_addr", bus0.imem_req_addr, 32'h0000_2000);
        step();
        #1;
        chk_b("rd_n2_req_vld", bus0.imem_req_valid, 1'b1);
        chk("rd_n2_addr", bus0.imem_req_addr, 32'h0000_2000);
        repeat (5) step();
        chk("rd_first_pc", (got_pc.size() > 0) ? got_pc[0] : 32'hDEAD_BEEF, 32'h0000_2000);
        chk("rd_first_inst", (got_inst.size() > 0) ? got_inst[0] : 32'hDEAD_BEEF, mdata(32'h0000_2000));

        // Redirect coinciding with a request handshake, a response and a decode pop.
        do_reset();
        bus0.imem_req_ready = 1'b1;
        bus0.inst_ready     = 1'b1;
        lat = 1;
        #1;
        step();
        step();
        bus0.redirect_valid = 1'b1;
        bus0.redirect_pc    = 32'h0000_3000;
        #1;
        chk_b("sim_req_vld", bus0.imem_req_valid, 1'b1);
        chk_b("sim_rsp_vld", bus0.imem_rsp_valid, 1'b1);
        chk_b("sim_inst_vld", bus0.inst_valid, !BYP);
        step();
        bus0.redirect_valid = 1'b0;
        #1;
        chk_b("sim_n1_inst_vld", bus0.inst_valid, 1'b0);
        chk_b("sim_n1_req_vld", bus0.imem_req_valid, 1'b1);
        chk("sim_n1_addr", bus0.imem_req_addr, 32'h0000_3000);
        repeat (3) step();
        chk("sim_deliv0", (got_pc.size() > 0) ? got_pc[0] : 32'hDEAD_BEEF, 32'h0000_0100);
        chk("sim_deliv1", (got_pc.size() > 1) ? got_pc[1] : 32'hDEAD_BEEF, 32'h0000_3000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
